// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
// Holds the transmit-queue launch sequencer states and parameter defaults.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } txq_state_e;

    localparam int TXQ_DEPTH_DEF = 16;
    localparam int TXQ_TMO_DEF   = 16;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Handshake bundle between the user/transmitter side and the transmit queue.
// master = environment (producer and transmitter), slave = the queue itself.
interface uart_tx_queue_if
    import uart_pkg::*;
#(
    parameter int DEPTH = TXQ_DEPTH_DEF
);
    localparam int AW = $clog2(DEPTH);

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          clr_err;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          tx_err;
    logic [7:0]    data;
    logic          valid_tx;
    logic          busy_tx;

    modport master (
        output wr_en, wr_data, clr_err, busy_tx,
        input  full, empty, count, overflow, tx_err, data, valid_tx
    );

    modport slave (
        input  wr_en, wr_data, clr_err, busy_tx,
        output full, empty, count, overflow, tx_err, data, valid_tx
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Circular byte FIFO with one extra pointer bit so full and empty are distinguishable.
// count/full/empty are decoded from the registered pointers only.
module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Storage carries no reset; occupancy is governed solely by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue plus launch sequencer feeding the UART transmitter one byte at a time.
// A launch that the transmitter never acknowledges is dropped and flagged in tx_err.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH      = TXQ_DEPTH_DEF,
    parameter int LAUNCH_TMO = TXQ_TMO_DEF
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_queue_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(LAUNCH_TMO + 1);

    txq_state_e    state;
    txq_state_e    state_nxt;
    logic [TW-1:0] tmo_cnt;
    logic          pop;
    logic          timeout;
    logic          push;
    logic [7:0]    head;
    logic [7:0]    data_q;
    logic          overflow_q;
    logic          tx_err_q;
    logic          full;
    logic          empty;
    logic [AW:0]   count;

    // A write while full is dropped even if a pop frees a slot in the same cycle.
    assign push = bus.wr_en && !full;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (bus.wr_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !bus.busy_tx) begin
                    pop       = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (bus.busy_tx) begin
                    state_nxt = WAIT_DONE;
                end else if (tmo_cnt == TW'(LAUNCH_TMO - 1)) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!bus.busy_tx) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sticky flags: a set event in the clearing cycle takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            data_q     <= '0;
            overflow_q <= 1'b0;
            tx_err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                data_q <= head;
            end
            if (state == LAUNCH) begin
                tmo_cnt <= '0;
            end else if (state == WAIT_BUSY && !bus.busy_tx && !timeout) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (bus.wr_en && full) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_err) begin
                overflow_q <= 1'b0;
            end
            if (timeout) begin
                tx_err_q <= 1'b1;
            end else if (bus.clr_err) begin
                tx_err_q <= 1'b0;
            end
        end
    end

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.count    = count;
    assign bus.overflow = overflow_q;
    assign bus.tx_err   = tx_err_q;
    assign bus.data     = data_q;
    assign bus.valid_tx = (state == LAUNCH);

endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
Byte queue and launch sequencer directly upstream of the UART transmitter.
- Accepts bytes from the user side through a write strobe and buffers them in a circular FIFO.
- Presents one byte at a time to the transmitter through its data/valid_tx/busy_tx handshake, so producers are never blocked by the serial rate.
- Instantiated next to the UART top level, driving its data and valid_tx inputs and observing busy_tx.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- AW, $clog2(DEPTH), pointer index width; derived, not overridden.
- LAUNCH_TMO, 16, maximum cycles to wait for busy_tx to rise after a launch pulse; must be >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  write strobe, one byte per cycle.
- wr_data  in  8  byte to enqueue.
- clr_err  in  1  clears the sticky overflow and tx_err flags.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- count  out  AW+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; a write was dropped.
- tx_err  out  1  sticky; a launch timed out.
- data  out  8  byte presented to the transmitter.
- valid_tx  out  1  one-cycle launch pulse to the transmitter.
- busy_tx  in  1  transmitter busy.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Pointers, count, data, valid_tx, overflow and tx_err go to 0; empty=1, full=0; FSM goes to IDLE.
  - Mid-operation reset discards all queued bytes and any byte in flight. valid_tx is 0 from the next cycle.
- FIFO storage:
  - Read and write pointers are AW+1 bits wide and wrap modulo 2*DEPTH; the index is the low AW bits.
  - count = wr_ptr - rd_ptr. full and empty are decoded from registered state.
- Write:
  - A write with wr_en=1 and full=0 stores wr_data and increments wr_ptr. count updates the next cycle.
  - A write with wr_en=1 and full=1 is dropped and sets overflow. This holds even if a pop occurs in the same cycle.
- Pop:
  - Occurs only on the IDLE->LAUNCH transition and is based on registered empty.
  - A write into an empty FIFO is never popped in its own cycle.
  - A simultaneous write and pop on a non-empty, non-full FIFO leaves count unchanged.
- FSM:
  - IDLE: if !empty && !busy_tx, load data <= head, increment rd_ptr, go to LAUNCH.
  - LAUNCH: valid_tx=1 for exactly this cycle; clear the timeout counter; go to WAIT_BUSY.
  - WAIT_BUSY: if busy_tx=1, go to WAIT_DONE. Otherwise increment the counter. When the counter reaches LAUNCH_TMO, set tx_err, discard the byte and go to IDLE.
  - WAIT_DONE: if busy_tx=0, go to IDLE.
- data is held stable from LAUNCH until the FSM re-enters IDLE.
- Latency:
  - A write at edge t into an empty FIFO, with busy_tx=0, gives a pop at edge t+1 and valid_tx=1 during cycle t+2.
  - Back-to-back bytes require busy_tx to fall, then IDLE, then LAUNCH. The minimum gap between launch pulses is 3 cycles plus the busy time.
- Sticky flags:
  - overflow and tx_err clear only on rst or clr_err.
  - A set event in the same cycle as clr_err wins, and the flag stays 1.
- Each FIFO entry is transmitted at most once; no retry after a timeout.

Decomposition:
- uart_pkg gains:
  - the typedef enum txq_state_e {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE};
  - the constants TXQ_DEPTH_DEF=16 and TXQ_TMO_DEF=16.
- Sub-module uart_sync_fifo holds storage, pointers, count, full and empty, with push, pop and head ports.
- uart_tx_queue holds the FSM, the timeout counter and the sticky flags.

Test Plan:
1. Hold rst=1 for 2 cycles, then release -> empty=1, full=0, count=0, valid_tx=0, overflow=0, tx_err=0.
2. Write 0xA5 with the transmitter idle; the bench model raises busy_tx 1 cycle after valid_tx and holds it 10 cycles -> valid_tx high exactly once, 2 cycles after the write; data=0xA5 stable until busy_tx falls; count back to 0.
3. Hold busy_tx=1 and write 0x00..0x0F, then 0xFF -> full=1, count=16, 0xFF dropped, overflow=1; release busy -> 0x00..0x0F transmitted in order; pulse clr_err -> overflow=0.
4. Stream 40 bytes 0x30..0x57 with random write gaps against the bench transmitter model -> output order identical, count never exceeds 16, pointer wrap exercised at least twice.
5. Queue 0x11 and 0x22; the bench model never raises busy_tx in response to the first launch (LAUNCH_TMO=16) -> tx_err=1 after 16 cycles in WAIT_BUSY; 0x11 discarded, 0x22 launched next.
6. Queue 5 bytes and assert rst while in WAIT_DONE -> count=0, empty=1, no further valid_tx pulses with busy_tx released.
